// File: rtl/cwe1280_protected_reader_if.sv
// Bus bundle for the protected asset reader: request, asset-bank and response channels.
// The slave modport is the reader itself; the master side is the requester plus asset bank.
interface cwe1280_protected_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int ID_W   = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ID_W-1:0]   usr_id;
    logic              asset_rd_en;
    logic [ADDR_W-1:0] asset_addr;
    logic [DATA_W-1:0] asset_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              locked;
    logic [2:0]        deny_cnt;

    modport slave (
        input  req_valid, req_addr, usr_id, asset_rdata, rsp_ready,
        output req_ready, asset_rd_en, asset_addr, rsp_valid, rsp_data, rsp_err,
               locked, deny_cnt
    );

    modport master (
        output req_valid, req_addr, usr_id, asset_rdata, rsp_ready,
        input  req_ready, asset_rd_en, asset_addr, rsp_valid, rsp_data, rsp_err,
               locked, deny_cnt
    );
endinterface

// File: rtl/cwe1280_protected_reader.sv
// Access-controlled read port for the protected asset bank: policy check before any asset
// access, constant grant/deny latency, and a timed lockout after repeated denials.
module cwe1280_protected_reader #(
    parameter int                      DATA_W      = 8,
    parameter int                      ADDR_W      = 2,
    parameter int                      ID_W        = 3,
    parameter logic [ID_W-1:0]         AUTH_ID     = 3'h4,
    parameter logic [(1<<ADDR_W)-1:0]  PUBLIC_MASK = 4'b0001,
    parameter int                      LOCK_THRESH = 3,
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    cwe1280_protected_reader_if.slave      bus
);
    localparam logic [2:0] THRESH = 3'(LOCK_THRESH);
    localparam logic [7:0] LCYC   = 8'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic              r_grant;
    logic              r_req_ready;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_asset_addr;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_locked;
    logic [2:0]        r_deny_cnt;
    logic [7:0]        r_timer;

    logic              w_public;
    logic              w_grant;
    logic [2:0]        w_cnt_inc;

    assign w_public  = PUBLIC_MASK[r_addr];
    assign w_grant   = w_public | (!r_locked && (r_id == AUTH_ID));
    assign w_cnt_inc = r_deny_cnt + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_id         <= '0;
            r_grant      <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rd_en      <= 1'b0;
            r_asset_addr <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_locked     <= 1'b0;
            r_deny_cnt   <= '0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_id        <= bus.usr_id;
                        r_req_ready <= 1'b0;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_grant      <= w_grant;
                    r_rd_en      <= w_grant;
                    r_asset_addr <= w_grant ? r_addr : '0;
                    if (!w_grant) begin
                        if (!r_locked) begin
                            r_deny_cnt <= w_cnt_inc;
                            if (w_cnt_inc == THRESH) begin
                                r_locked <= 1'b1;
                                r_timer  <= LCYC;
                            end
                        end
                    end else if (!w_public) begin
                        r_deny_cnt <= '0;
                    end
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_rd_en      <= 1'b0;
                    r_asset_addr <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Deny path takes the same cycle count but never samples asset data.
                    r_rsp_data  <= r_grant ? bus.asset_rdata : '0;
                    r_rsp_err   <= !r_grant;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase

            // Placed after the FSM so an expiry on a CHECK edge wins the deny_cnt update.
            if (r_locked) begin
                if (r_timer == 8'd1) begin
                    r_locked   <= 1'b0;
                    r_deny_cnt <= '0;
                    r_timer    <= '0;
                end else begin
                    r_timer <= r_timer - 8'd1;
                end
            end
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.asset_rd_en = r_rd_en;
    assign bus.asset_addr  = r_asset_addr;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.locked      = r_locked;
    assign bus.deny_cnt    = r_deny_cnt;
endmodule

// File: tb/tb_cwe1280_protected_reader.sv
// Scoreboard bench for the protected reader: stimulus queues expected responses, a
// monitor pops them on each response handshake and checks strobes, latency and holds.
module tb_cwe1280_protected_reader;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int IW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cwe1280_protected_reader_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus ();

    cwe1280_protected_reader #(
        .DATA_W(DW), .ADDR_W(AW), .ID_W(IW),
        .AUTH_ID(3'h4), .PUBLIC_MASK(4'b0001),
        .LOCK_THRESH(3), .LOCK_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [1:0] addr;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] mem[4];

    always @(posedge clk) cyc = cyc + 1;

    // Asset bank model: one-cycle read latency
    initial bus.asset_rdata = '0;
    always @(posedge clk)
        if (bus.asset_rd_en) bus.asset_rdata <= mem[bus.asset_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    int         acc_cyc   = -100;
    int         strobes   = 0;
    int         lock_rise = 0;
    logic       pv        = 1'b0;
    logic       pstall    = 1'b0;
    logic       plock     = 1'b0;
    logic [7:0] pd        = '0;
    logic       pe        = 1'b0;
    exp_t       e;

    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            strobes = 0;
            pv      = 1'b0;
            pstall  = 1'b0;
            plock   = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc = cyc + 1;
                strobes = 0;
            end
            if (bus.asset_rd_en) begin
                strobes++;
                chk("strobe_latency", cyc - acc_cyc, 1);
                chk("strobe_has_txn", int'(q.size() > 0), 1);
                if (q.size() > 0) chk("strobe_addr", int'(bus.asset_addr), int'(q[0].addr));
            end
            if (bus.rsp_valid && !pv) chk("rsp_latency", cyc - acc_cyc, 3);
            if (pstall) begin
                chk("hold_valid", int'(bus.rsp_valid), 1);
                chk("hold_data", int'(bus.rsp_data), int'(pd));
                chk("hold_err", int'(bus.rsp_err), int'(pe));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_has_txn", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rsp_data", int'(bus.rsp_data), int'(e.data));
                    chk("rsp_err", int'(bus.rsp_err), int'(e.err));
                    chk("rd_strobes", strobes, e.err ? 0 : 1);
                end
            end
            if (bus.locked && !plock) lock_rise = cyc;
            if (!bus.locked && plock) chk("lock_duration", cyc - lock_rise, 16);
            pstall = bus.rsp_valid && !bus.rsp_ready;
            pd     = bus.rsp_data;
            pe     = bus.rsp_err;
            pv     = bus.rsp_valid;
            plock  = bus.locked;
        end
    end

    task automatic send(input logic [1:0] a, input logic [2:0] id,
                        input logic [7:0] d, input logic err);
        int n;
        exp_t x;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.usr_id    = id;
        x.data = d;
        x.err  = err;
        x.addr = a;
        q.push_back(x);
        n = 0;
        while (!bus.req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", int'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.rsp_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_data"}, int'(bus.rsp_data), 0);
        chk({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
        chk({tag, "_asset_rd_en"}, int'(bus.asset_rd_en), 0);
        chk({tag, "_asset_addr"}, int'(bus.asset_addr), 0);
        chk({tag, "_locked"}, int'(bus.locked), 0);
        chk({tag, "_deny_cnt"}, int'(bus.deny_cnt), 0);
    endtask

    initial begin
        int n;
        mem[0] = 8'h11;
        mem[1] = 8'hAB;
        mem[2] = 8'hCD;
        mem[3] = 8'hEF;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.usr_id    = '0;
        bus.rsp_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        send(2'd1, 3'd4, 8'hAB, 1'b0); drain();
        chk("auth_deny_cnt", int'(bus.deny_cnt), 0);
        send(2'd2, 3'd3, 8'h00, 1'b1); drain();
        chk("unauth_deny_cnt", int'(bus.deny_cnt), 1);
        chk("unauth_locked", int'(bus.locked), 0);
        send(2'd0, 3'd3, 8'h11, 1'b0); drain();
        chk("public_deny_cnt", int'(bus.deny_cnt), 1);
        send(2'd2, 3'd4, 8'hCD, 1'b0); drain();
        chk("clear_deny_cnt", int'(bus.deny_cnt), 0);

        for (int i = 0; i < 3; i++) begin
            send(2'd3, 3'd2, 8'h00, 1'b1);
            drain();
            chk("lock_build_cnt", int'(bus.deny_cnt), i + 1);
        end
        chk("lock_set", int'(bus.locked), 1);
        send(2'd1, 3'd4, 8'h00, 1'b1); drain();
        chk("locked_no_inc", int'(bus.deny_cnt), 3);
        chk("still_locked", int'(bus.locked), 1);
        n = 0;
        while (bus.locked && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("unlock", int'(bus.locked), 0);
        chk("unlock_deny_cnt", int'(bus.deny_cnt), 0);
        send(2'd1, 3'd4, 8'hAB, 1'b0); drain();

        // Backpressure with a second request held pending
        bus.rsp_ready = 1'b0;
        send(2'd3, 3'd4, 8'hEF, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd0;
        bus.usr_id    = 3'd4;
        e.data = 8'h11;
        e.err  = 1'b0;
        e.addr = 2'd0;
        q.push_back(e);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_ready", int'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_accept", int'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        drain();

        // Reset while in FETCH
        send(2'd1, 3'd4, 8'hAB, 1'b0);
        @(posedge clk);
        #2;
        chk("fetch_strobe", int'(bus.asset_rd_en), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_rsp_after_rst", int'(bus.rsp_valid), 0);
        send(2'd0, 3'd3, 8'h11, 1'b0); drain();
        send(2'd2, 3'd4, 8'hCD, 1'b0); drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
